// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Shares a single ALU between NUM_REQ requesters. Requests are granted
//   round-robin, one op per valid/ready handshake. The ALU is driven through
//   ISSUE (one enable pulse) and WAIT (wait for alu_ready, bounded by
//   TIMEOUT cycles). The result is returned on one response channel tagged
//   with the requester id. Every output is registered.
//
// Optional feature (macro ALU_ARB_OPCHK_EN):
//   When defined, an op outside 1..13 is still accepted but answered
//   directly with rsp_err=1 and is never issued to the ALU.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is a 1-cycle one-hot pulse)
//   req_op/in1/in2        packed per-requester fields (5/8/8 bits per requester)
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/out/status/err response payload; status = {carry, neg, eq, lt, gt}
//   alu_enable/op/in1/in2 drive the ALU
//   alu_out/status/ready  results from the ALU
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [5*NUM_REQ-1:0] req_op,
  input  logic [8*NUM_REQ-1:0] req_in1,
  input  logic [8*NUM_REQ-1:0] req_in2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_out,
  output logic [4:0]           rsp_status,
  output logic                 rsp_err,
  output logic                 alu_enable,
  output logic [4:0]           alu_op,
  output logic [7:0]           alu_in1,
  output logic [7:0]           alu_in2,
  input  logic [7:0]           alu_out,
  input  logic [4:0]           alu_status,
  input  logic                 alu_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [IDW:0]         NREQ_W  = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0]       PTR_RST = IDW'(NUM_REQ-1);
  localparam logic [7:0]           TO_LAST = 8'(TIMEOUT-1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic [IDW-1:0]       ptr, ptr_nxt;
  logic [7:0]           cnt, cnt_nxt;
  logic [NUM_REQ-1:0]   req_ready_nxt;
  logic                 alu_enable_nxt;
  logic [4:0]           alu_op_nxt;
  logic [7:0]           alu_in1_nxt, alu_in2_nxt;
  logic                 rsp_valid_nxt, rsp_err_nxt;
  logic [IDW-1:0]       rsp_id_nxt;
  logic [7:0]           rsp_out_nxt;
  logic [4:0]           rsp_status_nxt;

  logic                 any_valid;
  logic [IDW-1:0]       grant;
  logic [IDW:0]         cand;
  logic [IDW-1:0]       cand_idx;
  logic [4:0]           sel_op;
  logic [7:0]           sel_in1, sel_in2;
  logic                 op_reject;

  // Round-robin search: the first valid requester after the last grant wins.
  // cand carries one extra bit so ptr+k can be wrapped without overflow.
  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      cand_idx = cand[IDW-1:0];
      if (!any_valid && req_valid[cand_idx]) begin
        any_valid = 1'b1;
        grant     = cand_idx;
      end
    end
  end

  // Select the granted requester's packed fields.
  always_comb begin
    sel_op  = '0;
    sel_in1 = '0;
    sel_in2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_op  = req_op[5*i +: 5];
        sel_in1 = req_in1[8*i +: 8];
        sel_in2 = req_in2[8*i +: 8];
      end
    end
  end

`ifdef ALU_ARB_OPCHK_EN
  assign op_reject = (sel_op == 5'd0) || (sel_op > 5'd13);
`else
  assign op_reject = 1'b0;
`endif

  // State register plus every registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= PTR_RST;
      cnt        <= '0;
      req_ready  <= '0;
      alu_enable <= 1'b0;
      alu_op     <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_out    <= '0;
      rsp_status <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= req_ready_nxt;
      alu_enable <= alu_enable_nxt;
      alu_op     <= alu_op_nxt;
      alu_in1    <= alu_in1_nxt;
      alu_in2    <= alu_in2_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_id     <= rsp_id_nxt;
      rsp_out    <= rsp_out_nxt;
      rsp_status <= rsp_status_nxt;
      rsp_err    <= rsp_err_nxt;
    end
  end

  // Next-state and next-output logic. Response fields and ALU operands hold
  // by default; req_ready and alu_enable are pulses and default low.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    cnt_nxt        = cnt;
    req_ready_nxt  = '0;
    alu_enable_nxt = 1'b0;
    alu_op_nxt     = alu_op;
    alu_in1_nxt    = alu_in1;
    alu_in2_nxt    = alu_in2;
    rsp_valid_nxt  = rsp_valid;
    rsp_id_nxt     = rsp_id;
    rsp_out_nxt    = rsp_out;
    rsp_status_nxt = rsp_status;
    rsp_err_nxt    = rsp_err;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready_nxt = ONE_HOT << grant;
          ptr_nxt       = grant;
          rsp_id_nxt    = grant;
          cnt_nxt       = '0;
          if (op_reject) begin
            state_nxt      = RESP;
            rsp_valid_nxt  = 1'b1;
            rsp_out_nxt    = '0;
            rsp_status_nxt = '0;
            rsp_err_nxt    = 1'b1;
          end else begin
            state_nxt      = ISSUE;
            alu_enable_nxt = 1'b1;
            alu_op_nxt     = sel_op;
            alu_in1_nxt    = sel_in1;
            alu_in2_nxt    = sel_in2;
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        if (alu_ready) begin
          state_nxt      = RESP;
          rsp_valid_nxt  = 1'b1;
          rsp_out_nxt    = alu_out;
          rsp_status_nxt = alu_status;
          rsp_err_nxt    = 1'b0;
          cnt_nxt        = '0;
        end else if (cnt == TO_LAST) begin
          // This is the TIMEOUT-th WAIT cycle without alu_ready.
          state_nxt      = RESP;
          rsp_valid_nxt  = 1'b1;
          rsp_out_nxt    = '0;
          rsp_status_nxt = '0;
          rsp_err_nxt    = 1'b1;
          cnt_nxt        = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
          alu_op_nxt    = '0;
          alu_in1_nxt   = '0;
          alu_in2_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter
//   Self-checking bench for alu_rr_arbiter. A behavioural ALU answers one
//   cycle after alu_enable (or never, while alu_stall is set). Expected
//   grants come from a round-robin model over the request mask; expected
//   payloads come from the ALU function applied to the granted fields.
//   Honors ALU_ARB_OPCHK_EN for the illegal-opcode expectations.
module tb_alu_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 15;
  localparam int IDW     = 2;
`ifdef ALU_ARB_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [5*NUM_REQ-1:0] req_op;
  logic [8*NUM_REQ-1:0] req_in1;
  logic [8*NUM_REQ-1:0] req_in2;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [7:0]           rsp_out;
  logic [4:0]           rsp_status;
  logic                 rsp_err;
  logic                 alu_enable;
  logic [4:0]           alu_op;
  logic [7:0]           alu_in1, alu_in2;
  logic [7:0]           alu_out;
  logic [4:0]           alu_status;
  logic                 alu_ready;
  logic                 alu_stall;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int en_count = 0;

  logic [4:0] op_q [NUM_REQ];
  logic [7:0] a_q  [NUM_REQ];
  logic [7:0] b_q  [NUM_REQ];

  wire [42:0] all_outs = {req_ready, rsp_valid, rsp_id, rsp_out, rsp_status, rsp_err,
                          alu_enable, alu_op, alu_in1, alu_in2};

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_status(rsp_status), .rsp_err(rsp_err),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_status(alu_status), .alu_ready(alu_ready)
  );

  always #5 clk = ~clk;

  // Free-running cycle count, used to measure grant spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Count the cycles the ALU actually sees alu_enable.
  always @(posedge clk) if (alu_enable) en_count <= en_count + 1;

  // ALU function: returns {status, out}, status = {carry, neg, eq, lt, gt}.
  function automatic logic [12:0] alu_ref(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic lt, gt, eq;
    s = '0; lt = 1'b0; gt = 1'b0;
    case (op)
      5'd1:  s = {1'b0, a} + {1'b0, b};
      5'd2:  s = {1'b0, a} - {1'b0, b};
      5'd3:  s = {1'b0, a & b};
      5'd4:  s = {1'b0, a | b};
      5'd5:  s = {1'b0, a ^ b};
      5'd6:  s = {a, 1'b0};
      5'd7:  s = {a[0], 1'b0, a[7:1]};
      5'd8:  s = {1'b0, ~a};
      5'd9:  s = {1'b0, a} + 9'd1;
      5'd10: s = {1'b0, a} - 9'd1;
      5'd11: s = {1'b0, b};
      5'd12: s = {1'b0, a};
      5'd13: begin lt = (a < b); gt = (a > b); end
      default: return 13'd0;
    endcase
    r  = s[7:0];
    eq = (op == 5'd13) ? (a == b) : (r == 8'd0);
    return {s[8], r[7], eq, lt, gt, r};
  endfunction

  // Behavioural ALU with a one-cycle output register.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_out    <= '0;
      alu_status <= '0;
      alu_ready  <= 1'b0;
    end else begin
      alu_ready <= alu_enable && !alu_stall;
      if (alu_enable) {alu_status, alu_out} <= alu_ref(alu_op, alu_in1, alu_in2);
    end
  end

  // Round-robin reference: first set bit of the mask after the last grant.
  function automatic int next_grant(input int last, input logic [NUM_REQ-1:0] mask);
    int c;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (last + k) % NUM_REQ;
      if (mask[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int idx, input logic [4:0] op, input logic [7:0] a,
                               input logic [7:0] b);
    op_q[idx] = op;
    a_q[idx]  = a;
    b_q[idx]  = b;
    req_op[5*idx +: 5]  = op;
    req_in1[8*idx +: 8] = a;
    req_in2[8*idx +: 8] = b;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic randomFields(input int idx);
    applyStimulus(idx, 5'($urandom_range(1, 13)), 8'($urandom), 8'($urandom));
  endtask

  // Wait (bounded) until some req_ready bit is seen.
  task automatic waitGrant();
    for (int n = 0; n < 64; n++) begin
      if (req_ready != '0) break;
      tick();
    end
    checkOutput("grant_seen", 64'(req_ready != '0), 64'd1);
  endtask

  // Wait (bounded) for rsp_valid; n is the number of cycles waited.
  task automatic waitRsp(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (rsp_valid) break;
      tick();
      n++;
    end
    checkOutput("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  // Hang guard in case a wait is ever defeated.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int last, exp_g, n, prev_cyc, en0;
    logic [NUM_REQ-1:0] mask;
    logic [12:0] exp_r;

    req_valid = '0; req_op = '0; req_in1 = '0; req_in2 = '0;
    rsp_ready = 1'b1; alu_stall = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 5'd0, 8'd0, 8'd0);
    last = NUM_REQ - 1;
    prev_cyc = 0;

    // Reset values.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", 64'(all_outs), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single request from requester 0: add 0xF0 + 0x20.
    applyStimulus(0, 5'd1, 8'hF0, 8'h20);
    req_valid = 4'b0001;
    tick();
    checkOutput("single_accept", 64'({req_ready, alu_enable, alu_op, alu_in1, alu_in2, rsp_valid}),
                64'({4'b0001, 1'b1, 5'd1, 8'hF0, 8'h20, 1'b0}));
    req_valid = '0;
    last = 0;
    tick();
    checkOutput("single_wait", 64'({req_ready, alu_enable, alu_op, rsp_valid}),
                64'({4'b0000, 1'b0, 5'd1, 1'b0}));
    tick();
    checkOutput("single_rsp", 64'({rsp_valid, rsp_id, rsp_status, rsp_out, rsp_err}),
                64'({1'b1, 2'd0, 5'b10000, 8'h10, 1'b0}));
    tick();
    checkOutput("single_done", 64'({rsp_valid, alu_op, alu_in1, alu_in2}), 64'd0);

    // Round robin: 8 grants with all requesters valid, then 16 with random masks.
    for (int i = 0; i < NUM_REQ; i++) randomFields(i);
    mask = 4'hF;
    req_valid = mask;
    for (int t = 0; t < 24; t++) begin
      exp_g = next_grant(last, mask);
      waitGrant();
      checkOutput("rr_grant", 64'(req_ready), 64'(4'b0001 << exp_g));
      if (t > 0) checkOutput("rr_spacing", 64'(cyc - prev_cyc), 64'd4);
      prev_cyc = cyc;
      last = exp_g;
      exp_r = alu_ref(op_q[exp_g], a_q[exp_g], b_q[exp_g]);
      randomFields(exp_g);
      mask = (t >= 7) ? 4'($urandom_range(1, 15)) : 4'hF;
      req_valid = mask;
      waitRsp(n);
      checkOutput("rr_rsp", 64'({rsp_id, rsp_status, rsp_out, rsp_err}),
                  64'({2'(exp_g), exp_r[12:8], exp_r[7:0], 1'b0}));
    end
    req_valid = '0;
    tick();

    // Backpressure: hold rsp_ready low for 10 cycles while requester 2 waits.
    rsp_ready = 1'b0;
    randomFields(1);
    req_valid = 4'b0010;
    exp_g = next_grant(last, 4'b0010);
    waitGrant();
    checkOutput("bp_grant", 64'(req_ready), 64'(4'b0010));
    last = exp_g;
    exp_r = alu_ref(op_q[1], a_q[1], b_q[1]);
    randomFields(2);
    req_valid = 4'b0100;
    waitRsp(n);
    checkOutput("bp_latency", 64'(n), 64'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_hold", 64'({rsp_valid, rsp_id, rsp_status, rsp_out, rsp_err, req_ready}),
                  64'({1'b1, 2'd1, exp_r[12:8], exp_r[7:0], 1'b0, 4'b0000}));
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_release", 64'(rsp_valid), 64'd0);
    tick();
    checkOutput("bp_next_grant", 64'(req_ready), 64'(4'b0100));
    last = 2;
    exp_r = alu_ref(op_q[2], a_q[2], b_q[2]);
    req_valid = '0;
    waitRsp(n);
    checkOutput("bp_next_rsp", 64'({rsp_id, rsp_status, rsp_out, rsp_err}),
                64'({2'd2, exp_r[12:8], exp_r[7:0], 1'b0}));

    // Timeout: the ALU never raises alu_ready.
    alu_stall = 1'b1;
    randomFields(3);
    req_valid = 4'b1000;
    waitGrant();
    checkOutput("to_grant", 64'(req_ready), 64'(4'b1000));
    last = 3;
    req_valid = '0;
    tick();
    checkOutput("to_wait_hold", 64'({alu_enable, alu_op, alu_in1, alu_in2}),
                64'({1'b0, op_q[3], a_q[3], b_q[3]}));
    waitRsp(n);
    checkOutput("to_latency", 64'(n), 64'(TIMEOUT));
    checkOutput("to_rsp", 64'({rsp_id, rsp_status, rsp_out, rsp_err}),
                64'({2'd3, 5'd0, 8'd0, 1'b1}));
    alu_stall = 1'b0;

    // Illegal opcode 20 from requester 0.
    applyStimulus(0, 5'd20, 8'($urandom), 8'($urandom));
    req_valid = 4'b0001;
    en0 = en_count;
    waitGrant();
    checkOutput("ill_grant", 64'(req_ready), 64'(4'b0001));
    last = 0;
    req_valid = '0;
    waitRsp(n);
    checkOutput("ill_latency", 64'(n), 64'(OPCHK ? 0 : 2));
    checkOutput("ill_rsp", 64'({rsp_id, rsp_status, rsp_out, rsp_err}),
                64'({2'd0, 5'd0, 8'd0, OPCHK}));
    tick();
    checkOutput("ill_enable_count", 64'(en_count - en0), 64'(OPCHK ? 0 : 1));

    // Reset during WAIT: everything clears at once, requester 0 wins afterwards.
    alu_stall = 1'b1;
    randomFields(2);
    req_valid = 4'b0100;
    waitGrant();
    checkOutput("rst_pre_grant", 64'(req_ready), 64'(4'b0100));
    randomFields(0);
    randomFields(2);
    req_valid = 4'b1111;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async", 64'(all_outs), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    alu_stall = 1'b0;
    last = NUM_REQ - 1;
    exp_g = next_grant(last, 4'b1111);
    waitGrant();
    checkOutput("rst_first_grant", 64'({req_ready, rsp_valid}), 64'({4'b0001 << exp_g, 1'b0}));
    exp_r = alu_ref(op_q[0], a_q[0], b_q[0]);
    req_valid = '0;
    waitRsp(n);
    checkOutput("rst_rsp_latency", 64'(n), 64'd2);
    checkOutput("rst_rsp", 64'({rsp_id, rsp_status, rsp_out, rsp_err}),
                64'({2'd0, exp_r[12:8], exp_r[7:0], 1'b0}));
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
